// File: rtl/conv_layer_seq_if.sv
// Bus bundle for conv_layer_seq: layer configuration and start/status,
// load-block handshake, convolve-engine pixel stream, partial-sum read port
// and output write port. The master side is the sequencer; the slave side is
// the surrounding controller, memories and engine.
interface conv_layer_seq_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16,
    parameter int CNT_W  = 8
);
    logic              start;
    logic [CNT_W-1:0]  cfg_in_ch;
    logic [CNT_W-1:0]  cfg_out_ch;
    logic [CNT_W-1:0]  cfg_img_size;
    logic [CNT_W-1:0]  cfg_flt_size;
    logic [ADDR_W-1:0] cfg_img_addr;
    logic [ADDR_W-1:0] cfg_flt_addr;
    logic [ADDR_W-1:0] cfg_out_addr;
    logic              busy;
    logic              done;
    logic              err;
    logic              ld_req;
    logic              ld_type;
    logic [ADDR_W-1:0] ld_addr;
    logic [CNT_W-1:0]  ld_size;
    logic              ld_ack;
    logic              cv_start;
    logic              cv_pix_valid;
    logic [DATA_W-1:0] cv_pix;
    logic              cv_pix_ready;
    logic              ps_rd_en;
    logic [ADDR_W-1:0] ps_rd_addr;
    logic [DATA_W-1:0] ps_rd_data;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;

    modport master (
        input  start, cfg_in_ch, cfg_out_ch, cfg_img_size, cfg_flt_size,
               cfg_img_addr, cfg_flt_addr, cfg_out_addr,
               ld_ack, cv_pix_valid, cv_pix, ps_rd_data,
        output busy, done, err, ld_req, ld_type, ld_addr, ld_size,
               cv_start, cv_pix_ready, ps_rd_en, ps_rd_addr,
               wr_en, wr_addr, wr_data
    );

    modport slave (
        output start, cfg_in_ch, cfg_out_ch, cfg_img_size, cfg_flt_size,
               cfg_img_addr, cfg_flt_addr, cfg_out_addr,
               ld_ack, cv_pix_valid, cv_pix, ps_rd_data,
        input  busy, done, err, ld_req, ld_type, ld_addr, ld_size,
               cv_start, cv_pix_ready, ps_rd_en, ps_rd_addr,
               wr_en, wr_addr, wr_data
    );
endinterface

// File: rtl/conv_layer_seq.sv
// Multi-channel convolution sequencer. For each output channel oc and each
// input channel ic it loads image ic and filter (oc,ic), starts the engine and
// accumulates the streamed pixels into output map oc with saturation.
// Optional feature macro: RELU_EN -- when defined, negative results written on
// the last input channel are clamped to zero.
module conv_layer_seq #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16,
    parameter int CNT_W  = 8
) (
    input  logic i_clk,
    input  logic i_reset,
    conv_layer_seq_if.master bus
);
    localparam int PW = 2 * CNT_W;

    typedef enum logic [2:0] {
        S_IDLE, S_CHECK, S_LD_IMG, S_LD_FLT, S_RUN, S_DRAIN, S_NEXT, S_DONE
    } state_t;

    state_t            r_state;
    logic [CNT_W-1:0]  r_in_ch, r_out_ch, r_n, r_k, r_ic, r_oc;
    logic [ADDR_W-1:0] r_img_base, r_flt_base, r_out_base;
    logic [ADDR_W-1:0] r_img_ptr, r_flt_ptr, r_out_ptr, r_pix_addr;
    logic [ADDR_W-1:0] r_nn, r_kk;
    logic [PW-1:0]     r_p, r_pix_cnt;
    logic              r_busy, r_done, r_err, r_ld_req, r_ld_type, r_cv_start, r_ready;
    logic [ADDR_W-1:0] r_ld_addr;
    logic [CNT_W-1:0]  r_ld_size;
    logic              r_p1_valid, r_p1_acc, r_p1_last;
    logic [DATA_W-1:0] r_p1_pix;
    logic [ADDR_W-1:0] r_p1_addr;
    logic              r_wr_en;
    logic [ADDR_W-1:0] r_wr_addr;
    logic [DATA_W-1:0] r_wr_data;

    logic              w_hs, w_acc, w_last, w_ic_more, w_oc_more;
    logic [CNT_W:0]    w_ic_inc, w_oc_inc;
    logic [CNT_W-1:0]  w_m;
    logic [PW-1:0]     w_p, w_nn, w_kk;
    logic [DATA_W-1:0] w_wr_val;

    // Signed add at DATA_W+1 bits, clamped to the DATA_W signed range.
    function automatic logic [DATA_W-1:0] sat_add(input logic [DATA_W-1:0] a,
                                                  input logic [DATA_W-1:0] b);
        logic [DATA_W:0] s;
        s = {a[DATA_W-1], a} + {b[DATA_W-1], b};
        if (s[DATA_W] != s[DATA_W-1]) begin
            sat_add = s[DATA_W] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
        end else begin
            sat_add = s[DATA_W-1:0];
        end
    endfunction

    assign w_hs      = bus.cv_pix_valid & r_ready;
    assign w_acc     = (r_ic != CNT_W'(0));
    assign w_ic_inc  = {1'b0, r_ic} + (CNT_W+1)'(1);
    assign w_oc_inc  = {1'b0, r_oc} + (CNT_W+1)'(1);
    assign w_ic_more = (w_ic_inc < {1'b0, r_in_ch});
    assign w_oc_more = (w_oc_inc < {1'b0, r_out_ch});
    assign w_last    = (w_ic_inc == {1'b0, r_in_ch});
    assign w_m       = r_n - r_k + CNT_W'(1);
    assign w_p       = PW'(w_m) * PW'(w_m);
    assign w_nn      = PW'(r_n) * PW'(r_n);
    assign w_kk      = PW'(r_k) * PW'(r_k);

    // Output value of the write stage: pass-through, saturated sum, optional ReLU.
    always_comb begin
        w_wr_val = r_p1_pix;
        if (r_p1_acc) begin
            w_wr_val = sat_add(r_p1_pix, bus.ps_rd_data);
        end else begin
            w_wr_val = r_p1_pix;
        end
`ifdef RELU_EN
        if (r_p1_last && w_wr_val[DATA_W-1]) begin
            w_wr_val = {DATA_W{1'b0}};
        end else begin
            w_wr_val = w_wr_val;
        end
`endif
    end

    // Layer sequencing FSM: channel loops, load handshakes, pass bookkeeping.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state <= S_IDLE;
            r_in_ch <= '0; r_out_ch <= '0; r_n <= '0; r_k <= '0; r_ic <= '0; r_oc <= '0;
            r_img_base <= '0; r_flt_base <= '0; r_out_base <= '0;
            r_img_ptr <= '0; r_flt_ptr <= '0; r_out_ptr <= '0; r_pix_addr <= '0;
            r_nn <= '0; r_kk <= '0; r_p <= '0; r_pix_cnt <= '0;
            r_busy <= 1'b0; r_done <= 1'b0; r_err <= 1'b0;
            r_ld_req <= 1'b0; r_ld_type <= 1'b0; r_ld_addr <= '0; r_ld_size <= '0;
            r_cv_start <= 1'b0; r_ready <= 1'b0;
        end else begin
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_cv_start <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_busy     <= 1'b1;
                        r_in_ch    <= bus.cfg_in_ch;
                        r_out_ch   <= bus.cfg_out_ch;
                        r_n        <= bus.cfg_img_size;
                        r_k        <= bus.cfg_flt_size;
                        r_img_base <= bus.cfg_img_addr;
                        r_flt_base <= bus.cfg_flt_addr;
                        r_out_base <= bus.cfg_out_addr;
                        r_state    <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    r_nn <= ADDR_W'(w_nn);
                    r_kk <= ADDR_W'(w_kk);
                    r_p  <= w_p;
                    if ((r_in_ch == CNT_W'(0)) || (r_out_ch == CNT_W'(0)) ||
                        (r_k == CNT_W'(0)) || (r_k > r_n)) begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_err   <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_ic      <= '0;
                        r_oc      <= '0;
                        r_img_ptr <= r_img_base;
                        r_flt_ptr <= r_flt_base;
                        r_out_ptr <= r_out_base;
                        r_ld_req  <= 1'b1;
                        r_ld_type <= 1'b0;
                        r_ld_addr <= r_img_base;
                        r_ld_size <= r_n;
                        r_state   <= S_LD_IMG;
                    end
                end
                S_LD_IMG: begin
                    if (bus.ld_ack) begin
                        r_ld_type <= 1'b1;
                        r_ld_addr <= r_flt_ptr;
                        r_ld_size <= r_k;
                        r_state   <= S_LD_FLT;
                    end
                end
                S_LD_FLT: begin
                    if (bus.ld_ack) begin
                        r_ld_req   <= 1'b0;
                        r_cv_start <= 1'b1;
                        r_ready    <= 1'b1;
                        r_pix_cnt  <= '0;
                        r_pix_addr <= r_out_ptr;
                        r_state    <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (w_hs) begin
                        r_pix_cnt  <= r_pix_cnt + PW'(1);
                        r_pix_addr <= r_pix_addr + ADDR_W'(1);
                        if (r_pix_cnt + PW'(1) == r_p) begin
                            r_ready <= 1'b0;
                            r_state <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    if (!r_p1_valid && !r_wr_en) begin
                        r_state <= S_NEXT;
                    end
                end
                S_NEXT: begin
                    r_flt_ptr <= r_flt_ptr + r_kk;
                    if (w_ic_more) begin
                        r_ic      <= w_ic_inc[CNT_W-1:0];
                        r_img_ptr <= r_img_ptr + r_nn;
                        r_ld_req  <= 1'b1;
                        r_ld_type <= 1'b0;
                        r_ld_addr <= r_img_ptr + r_nn;
                        r_ld_size <= r_n;
                        r_state   <= S_LD_IMG;
                    end else if (w_oc_more) begin
                        r_ic      <= '0;
                        r_oc      <= w_oc_inc[CNT_W-1:0];
                        r_img_ptr <= r_img_base;
                        r_out_ptr <= r_out_ptr + ADDR_W'(r_p);
                        r_ld_req  <= 1'b1;
                        // A single input image stays resident across output channels.
                        if (r_in_ch == CNT_W'(1)) begin
                            r_ld_type <= 1'b1;
                            r_ld_addr <= r_flt_ptr + r_kk;
                            r_ld_size <= r_k;
                            r_state   <= S_LD_FLT;
                        end else begin
                            r_ld_type <= 1'b0;
                            r_ld_addr <= r_img_base;
                            r_ld_size <= r_n;
                            r_state   <= S_LD_IMG;
                        end
                    end else begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Two-stage write pipeline: capture pixel at handshake, add and write next cycle.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_p1_valid <= 1'b0; r_p1_acc <= 1'b0; r_p1_last <= 1'b0;
            r_p1_pix <= '0; r_p1_addr <= '0;
            r_wr_en <= 1'b0; r_wr_addr <= '0; r_wr_data <= '0;
        end else begin
            r_p1_valid <= w_hs;
            if (w_hs) begin
                r_p1_pix  <= bus.cv_pix;
                r_p1_addr <= r_pix_addr;
                r_p1_acc  <= w_acc;
                r_p1_last <= w_last;
            end
            r_wr_en <= r_p1_valid;
            if (r_p1_valid) begin
                r_wr_addr <= r_p1_addr;
                r_wr_data <= w_wr_val;
            end
        end
    end

    assign bus.busy         = r_busy;
    assign bus.done         = r_done;
    assign bus.err          = r_err;
    assign bus.ld_req       = r_ld_req;
    assign bus.ld_type      = r_ld_type;
    assign bus.ld_addr      = r_ld_addr;
    assign bus.ld_size      = r_ld_size;
    assign bus.cv_start     = r_cv_start;
    assign bus.cv_pix_ready = r_ready;
    assign bus.ps_rd_en     = w_hs & w_acc;
    assign bus.ps_rd_addr   = r_pix_addr;
    assign bus.wr_en        = r_wr_en;
    assign bus.wr_addr      = r_wr_addr;
    assign bus.wr_data      = r_wr_data;
endmodule
